// File: rtl/div_pkg.sv
// Shared types and constants for the int_div_seq sequential divider.
// Optional build macro: DIV_ZERO_DETECT_EN (early exit on a zero divisor).
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_fsm.sv
// Control FSM and bit counter for int_div_seq; issues load/shift/sub strobes.
// The skip input (zero-divisor early exit) is driven low unless DIV_ZERO_DETECT_EN is set.
module div_fsm
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic skip,
    output logic load,
    output logic shift,
    output logic sub,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    count_d = CW'(WIDTH);
                end
            end
            SHIFT: begin
                if (skip) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    state_d = SUB;
                end
            end
            SUB: begin
                count_d = count_q - CW'(1);
                state_d = (count_q == CW'(1)) ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        sub   = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                load = start;
            end
            SHIFT:   shift = 1'b1;
            SUB:     sub   = 1'b1;
            DONE:    done  = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

endmodule

// File: rtl/int_div_seq.sv
// Sequential restoring divider: one shift and one conditional subtract per quotient bit.
// Build macro DIV_ZERO_DETECT_EN: a zero divisor finishes right after acceptance and flags div_by_zero.
module int_div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             load, shift, sub, skip;

`ifdef DIV_ZERO_DETECT_EN
    assign skip = (d_q == '0);
`else
    assign skip = 1'b0;
`endif

    div_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .skip  (skip),
        .load  (load),
        .shift (shift),
        .sub   (sub),
        .busy  (busy),
        .done  (done)
    );

    always_comb begin
        r_d = r_q;
        q_d = q_q;
        d_d = d_q;
        if (load) begin
            r_d = '0;
            q_d = dividend;
            d_d = divisor;
        end else if (shift) begin
            if (skip) begin
                // Zero divisor: publish the result the full algorithm would converge to.
                q_d = '1;
                r_d = {1'b0, q_q};
            end else begin
                {r_d, q_d} = {r_q[WIDTH-1:0], q_q, 1'b0};
            end
        end else if (sub) begin
            if (r_q >= {1'b0, d_q}) begin
                r_d    = r_q - {1'b0, d_q};
                q_d[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dz_q, dz_d;

    always_comb begin
        dz_d = dz_q;
        if (load)                dz_d = 1'b0;
        else if (shift && skip)  dz_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dz_q <= 1'b0;
        else      dz_q <= dz_d;
    end

    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign quotient  = q_q;
    assign remainder = r_q[WIDTH-1:0];

endmodule

// File: tb/tb_int_div_seq.sv
// Self-checking bench for int_div_seq: directed table, multi-cycle corner sequences,
// randomized operands against an arithmetic reference model, and an exhaustive nonzero sweep.
module tb_int_div_seq;

    localparam int W   = 4;
    localparam int LAT = 2 * W;
`ifdef DIV_ZERO_DETECT_EN
    localparam int ZLAT = 1;
    localparam int ZDZ  = 1;
`else
    localparam int ZLAT = 2 * W;
    localparam int ZDZ  = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

    int_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int lat;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model straight from the arithmetic definition of unsigned division.
    task automatic ref_div(input int a, input int b, output int q, output int r,
                           output int dz, output int lat);
        if (b == 0) begin
            q   = (1 << W) - 1;
            r   = a;
            dz  = ZDZ;
            lat = ZLAT;
        end else begin
            q   = a / b;
            r   = a % b;
            dz  = 0;
            lat = LAT;
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where done is seen.
    task automatic run_div(input int a, input int b, output int lat);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~W'(a);
        divisor  = ~W'(b);
        lat = -1;
        for (int k = 1; k <= 4 * W + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) break;
        end
    endtask

    task automatic apply_and_check(input string name, input vec_t v);
        int lat;
        run_div(v.a, v.b, lat);
        check({name, " latency"}, lat, v.lat);
        check({name, " quotient"}, int'(quotient), v.q);
        check({name, " remainder"}, int'(remainder), v.r);
        check({name, " div_by_zero"}, int'(div_by_zero), v.dz);
        check({name, " busy@done"}, int'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        check({name, " done pulse"}, int'(done), 0);
        check({name, " idle busy"}, int'(busy), 0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   lat;

        tbl[0] = '{a: 13, b: 4, q: 3,  r: 1, dz: 0,   lat: LAT};
        tbl[1] = '{a: 15, b: 1, q: 15, r: 0, dz: 0,   lat: LAT};
        tbl[2] = '{a: 0,  b: 5, q: 0,  r: 0, dz: 0,   lat: LAT};
        tbl[3] = '{a: 7,  b: 0, q: 15, r: 7, dz: ZDZ, lat: ZLAT};
        tbl[4] = '{a: 9,  b: 2, q: 4,  r: 1, dz: 0,   lat: LAT};
        tbl[5] = '{a: 6,  b: 3, q: 2,  r: 0, dz: 0,   lat: LAT};

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply_and_check($sformatf("table[%0d]", i), tbl[i]);

        // Results hold through idle cycles.
        repeat (3) @(negedge clk);
        check("hold quotient", int'(quotient), 2);
        check("hold remainder", int'(remainder), 0);

        // Start pulsed mid-division and held through DONE must be ignored.
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 4 * W + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k == 2);
            dividend = 4'd9; divisor = 4'd2;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("ignore latency", lat, LAT);
        check("ignore quotient", int'(quotient), 3);
        check("ignore remainder", int'(remainder), 1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start in DONE busy", int'(busy), 0);
        check("start in DONE quotient", int'(quotient), 3);
        @(negedge clk);
        check("start in DONE no queue", int'(busy), 0);
        apply_and_check("after ignore 9/2", tbl[4]);

        // Asynchronous reset mid-division.
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst quotient", int'(quotient), 0);
        check("midrst remainder", int'(remainder), 0);
        check("midrst div_by_zero", int'(div_by_zero), 0);
        lat = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) lat++;
        end
        check("midrst stays idle", lat, 0);
        rst = 1'b1;
        @(negedge clk);
        apply_and_check("after reset 6/3", tbl[5]);

        // Randomized operands, zero divisor included, with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            v.a = int'($urandom_range(0, 15));
            v.b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            ref_div(v.a, v.b, v.q, v.r, v.dz, v.lat);
            apply_and_check($sformatf("rand %0d/%0d", v.a, v.b), v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Exhaustive sweep of nonzero operand pairs.
        for (int a = 1; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                ref_div(a, b, v.q, v.r, v.dz, v.lat);
                run_div(a, b, lat);
                check($sformatf("sweep %0d/%0d latency", a, b), lat, v.lat);
                check($sformatf("sweep %0d/%0d quotient", a, b), int'(quotient), v.q);
                check($sformatf("sweep %0d/%0d remainder", a, b), int'(remainder), v.r);
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_div_seq.md
INT_DIV_SEQ -- requirements
Module: int_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH bits, unsigned dividend; captured when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH bits, unsigned divisor; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit, high from the accepting edge until done.
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient, output, WIDTH bits, result quotient.
REQ-010 SHALL have port remainder, output, WIDTH bits, result remainder.
REQ-011 SHALL have port div_by_zero, output, 1 bit, set with done when the captured divisor was 0.

Function
REQ-012 SHALL implement restoring division with a (WIDTH+1)-bit partial remainder R, a WIDTH-bit quotient register Q, and a down-counter of ceil(log2(WIDTH+1)) bits.
REQ-013 SHALL use FSM states IDLE, SHIFT, SUB, DONE.
REQ-014 IDLE: start=1 -> R=0, Q=dividend, D=divisor, count=WIDTH, go to SHIFT; start=0 -> stay.
REQ-015 SHIFT: {R,Q} shifted left one bit, Q[0]=0, go to SUB.
REQ-016 SUB: if R >= D then R=R-D and Q[0]=1, else R unchanged; count decremented; go to DONE if count reaches 0, else SHIFT.
REQ-017 DONE: done=1 for exactly this cycle, go to IDLE unconditionally.
REQ-018 Latency: done SHALL be high in the cycle following the 2*WIDTH-th rising edge after the edge that accepted start.
REQ-019 quotient=Q and remainder=R[WIDTH-1:0] SHALL be driven continuously and hold their values from DONE until the next accepted start.
REQ-020 start SHALL be ignored while busy=1, including in DONE; no queuing.
REQ-021 busy SHALL be 1 in SHIFT, SUB and DONE, and 0 in IDLE.
REQ-022 Dividend/divisor changes after acceptance SHALL NOT affect the running division.
REQ-023 div_by_zero SHALL clear on the next accepted start.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE, R=0, Q=0, count=0, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, including mid-division.
REQ-025 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-026 Macro DIV_ZERO_DETECT_EN defined: divisor==0 at acceptance SHALL go directly to DONE on the next edge with Q=all ones, R=dividend, div_by_zero=1.
REQ-027 Macro undefined: divisor 0 SHALL run the full 2*WIDTH-cycle algorithm, yielding Q=all ones and R=dividend, and div_by_zero SHALL be tied to 0.

Structure
REQ-028 Shared package div_pkg SHALL hold the state enum (IDLE, SHIFT, SUB, DONE) and the default width constant.
REQ-029 FSM and counter SHALL be a sub-module div_fsm issuing load/shift/sub controls; the datapath remains in int_div_seq.

Verification
REQ-030 WIDTH=4, dividend=13, divisor=4, start for one cycle -> done 9 cycles after start edge, quotient=3, remainder=1, div_by_zero=0.
REQ-031 dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=0, divisor=5 -> quotient=0, remainder=0.
REQ-032 With DIV_ZERO_DETECT_EN: dividend=7, divisor=0 -> done on the 2nd cycle, quotient=15, remainder=7, div_by_zero=1; without: done on the 9th cycle, same quotient and remainder, div_by_zero=0.
REQ-033 13/4 running, start pulsed with 9/2 at cycle 3 -> ignored; result 3 remainder 1; next start with 9/2 -> 4 remainder 1.
REQ-034 rst=0 at cycle 4 of a division -> all outputs 0 immediately, busy=0, no done; a fresh 6/3 afterwards -> 2 remainder 0.
REQ-035 Exhaustive sweep of all nonzero 4-bit operand pairs -> quotient and remainder match the reference model, with latency exactly 9 cycles for each.
